// File: rtl/anpc3_pkg.sv
// Shared types and step tables for the 3-level ANPC leg commutation sequencer.
package anpc3_pkg;

  typedef enum logic [2:0] {
    ST_ZU2 = 3'd0,
    ST_ZU1 = 3'd1,
    ST_ZL1 = 3'd2,
    ST_ZL2 = 3'd3,
    ST_P   = 3'd4,
    ST_N   = 3'd5
  } stable_e;

  typedef enum logic [1:0] {
    LVL_ZERO = 2'd0,
    LVL_P    = 2'd1,
    LVL_N    = 2'd2,
    LVL_HOLD = 2'd3
  } lvl_e;

  typedef enum logic [1:0] {
    CT_I   = 2'd0,
    CT_IU  = 2'd1,
    CT_II  = 2'd2,
    CT_III = 2'd3
  } ctype_e;

  typedef enum logic [1:0] {
    DW_S = 2'd0,
    DW_O = 2'd1,
    DW_V = 2'd2,
    DW_I = 2'd3
  } dsel_e;

  typedef enum logic [1:0] {
    LS_IDLE  = 2'd0,
    LS_RUN   = 2'd1,
    LS_FAULT = 2'd2
  } leg_fsm_e;

  localparam logic [5:0] PAT_P   = 6'b110_001;
  localparam logic [5:0] PAT_ZU2 = 6'b010_010;
  localparam logic [5:0] PAT_ZU1 = 6'b010_110;
  localparam logic [5:0] PAT_ZL1 = 6'b101_001;
  localparam logic [5:0] PAT_ZL2 = 6'b001_001;
  localparam logic [5:0] PAT_N   = 6'b001_110;

  typedef struct packed {
    logic [5:0] pat;
    dsel_e      dsel;
  } step_t;

  function automatic step_t mk_step(logic [5:0] pat, dsel_e dsel);
    step_t s;
    s.pat  = pat;
    s.dsel = dsel;
    return s;
  endfunction

  function automatic logic is_zero(stable_e st);
    return (st == ST_ZU2) || (st == ST_ZU1) || (st == ST_ZL1) || (st == ST_ZL2);
  endfunction

  function automatic stable_e zero_target(logic from_p, ctype_e ct);
    stable_e z;
    case (ct)
      CT_II:   z = from_p ? ST_ZL2 : ST_ZU2;
      CT_III:  z = from_p ? ST_ZL1 : ST_ZU1;
      default: z = from_p ? ST_ZU2 : ST_ZL2;
    endcase
    return z;
  endfunction

  // Index of the final step of the from->to list.
  function automatic logic [1:0] seq_last(stable_e from, stable_e to);
    logic [1:0] n;
    case ({from, to})
      {ST_ZU1, ST_P}, {ST_ZL1, ST_N}: n = 2'd3;
      {ST_ZU1, ST_N}, {ST_ZL1, ST_P},
      {ST_P, ST_ZL1}, {ST_N, ST_ZU1}: n = 2'd1;
      default:                        n = 2'd2;
    endcase
    return n;
  endfunction

  function automatic step_t step_lookup(stable_e from, stable_e to, logic [1:0] idx);
    logic [7:0] key;
    step_t      s;
    key = {from, to, idx};
    s   = mk_step(PAT_ZU2, DW_S);
    case (key)
      {ST_ZU2, ST_P, 2'd0}: s = mk_step(6'b010_000, DW_O);
      {ST_ZU2, ST_P, 2'd1}: s = mk_step(6'b110_000, DW_S);
      {ST_ZU2, ST_P, 2'd2}: s = mk_step(PAT_P,      DW_S);
      {ST_ZU2, ST_N, 2'd0}: s = mk_step(6'b011_010, DW_S);
      {ST_ZU2, ST_N, 2'd1}: s = mk_step(6'b001_010, DW_O);
      {ST_ZU2, ST_N, 2'd2}: s = mk_step(PAT_N,      DW_S);
      {ST_ZU1, ST_P, 2'd0}: s = mk_step(6'b010_010, DW_I);
      {ST_ZU1, ST_P, 2'd1}: s = mk_step(6'b010_011, DW_S);
      {ST_ZU1, ST_P, 2'd2}: s = mk_step(6'b010_001, DW_O);
      {ST_ZU1, ST_P, 2'd3}: s = mk_step(PAT_P,      DW_S);
      {ST_ZU1, ST_N, 2'd0}: s = mk_step(6'b000_110, DW_O);
      {ST_ZU1, ST_N, 2'd1}: s = mk_step(PAT_N,      DW_S);
      {ST_ZL1, ST_P, 2'd0}: s = mk_step(6'b100_001, DW_O);
      {ST_ZL1, ST_P, 2'd1}: s = mk_step(PAT_P,      DW_S);
      {ST_ZL1, ST_N, 2'd0}: s = mk_step(6'b001_001, DW_I);
      {ST_ZL1, ST_N, 2'd1}: s = mk_step(6'b001_011, DW_S);
      {ST_ZL1, ST_N, 2'd2}: s = mk_step(6'b001_010, DW_O);
      {ST_ZL1, ST_N, 2'd3}: s = mk_step(PAT_N,      DW_S);
      {ST_ZL2, ST_P, 2'd0}: s = mk_step(6'b011_001, DW_S);
      {ST_ZL2, ST_P, 2'd1}: s = mk_step(6'b010_001, DW_O);
      {ST_ZL2, ST_P, 2'd2}: s = mk_step(PAT_P,      DW_S);
      {ST_ZL2, ST_N, 2'd0}: s = mk_step(6'b001_000, DW_O);
      {ST_ZL2, ST_N, 2'd1}: s = mk_step(6'b001_100, DW_S);
      {ST_ZL2, ST_N, 2'd2}: s = mk_step(PAT_N,      DW_S);
      {ST_P, ST_ZU2, 2'd0}: s = mk_step(6'b110_000, DW_S);
      {ST_P, ST_ZU2, 2'd1}: s = mk_step(6'b010_000, DW_O);
      {ST_P, ST_ZU2, 2'd2}: s = mk_step(PAT_ZU2,    DW_S);
      {ST_P, ST_ZL1, 2'd0}: s = mk_step(6'b100_001, DW_O);
      {ST_P, ST_ZL1, 2'd1}: s = mk_step(PAT_ZL1,    DW_S);
      {ST_P, ST_ZL2, 2'd0}: s = mk_step(6'b010_001, DW_O);
      {ST_P, ST_ZL2, 2'd1}: s = mk_step(6'b011_001, DW_S);
      {ST_P, ST_ZL2, 2'd2}: s = mk_step(PAT_ZL2,    DW_S);
      {ST_N, ST_ZU2, 2'd0}: s = mk_step(6'b001_010, DW_O);
      {ST_N, ST_ZU2, 2'd1}: s = mk_step(6'b011_010, DW_V);
      {ST_N, ST_ZU2, 2'd2}: s = mk_step(PAT_ZU2,    DW_S);
      {ST_N, ST_ZU1, 2'd0}: s = mk_step(6'b000_110, DW_O);
      {ST_N, ST_ZU1, 2'd1}: s = mk_step(PAT_ZU1,    DW_S);
      {ST_N, ST_ZL2, 2'd0}: s = mk_step(6'b001_100, DW_S);
      {ST_N, ST_ZL2, 2'd1}: s = mk_step(6'b001_000, DW_O);
      {ST_N, ST_ZL2, 2'd2}: s = mk_step(PAT_ZL2,    DW_S);
      default:              s = mk_step(PAT_ZU2,    DW_S);
    endcase
    return s;
  endfunction

endpackage

// File: rtl/anpc3_leg.sv
// One ANPC leg: request decode, step sequencing with per-step dwell counter.
module anpc3_leg
  import anpc3_pkg::*;
#(
  parameter int unsigned TW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ce_i,
  input  logic [TW-1:0] t_short_i,
  input  logic [TW-1:0] t_off_on_i,
  input  logic [TW-1:0] t_on_offv0_i,
  input  logic [TW-1:0] t_off_oni0_i,
  input  logic [1:0]    req_i,
  input  logic [1:0]    comm_type_i,
  input  logic          kill_i,
  output logic [5:0]    s_o,
  output logic          busy_o
);

  leg_fsm_e      fsm_q, fsm_d;
  stable_e       cur_q, cur_d, tgt_q, tgt_d, fin_q, fin_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
  logic [5:0]    s_q, s_d;

  stable_e       zt, req_tgt, req_fin, new_from, new_to;
  logic [1:0]    new_idx;
  logic          accept, load, last_step;
  step_t         step_new;
  logic [TW-1:0] raw_dwell;

  assign zt        = zero_target(cur_q == ST_P, ctype_e'(comm_type_i));
  assign last_step = (idx_q == seq_last(cur_q, tgt_q));
  assign step_new  = step_lookup(new_from, new_to, new_idx);

  always_comb begin
    accept  = 1'b0;
    req_tgt = cur_q;
    req_fin = cur_q;
    unique case (lvl_e'(req_i))
      LVL_ZERO: if (!is_zero(cur_q)) begin
        accept  = 1'b1;
        req_tgt = zt;
        req_fin = zt;
      end
      LVL_P: if (cur_q != ST_P) begin
        accept  = 1'b1;
        req_fin = ST_P;
        req_tgt = (cur_q == ST_N) ? zt : ST_P;
      end
      LVL_N: if (cur_q != ST_N) begin
        accept  = 1'b1;
        req_fin = ST_N;
        req_tgt = (cur_q == ST_P) ? zt : ST_N;
      end
      default: ;
    endcase
  end

  always_comb begin
    fsm_d    = fsm_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    fin_d    = fin_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    new_from = cur_q;
    new_to   = tgt_q;
    new_idx  = idx_q;
    if (kill_i) begin
      fsm_d = LS_FAULT;
      idx_d = '0;
      cnt_d = '0;
    end else begin
      unique case (fsm_q)
        LS_FAULT: begin
          fsm_d = LS_IDLE;
          cur_d = ST_ZU2;
        end
        LS_IDLE: if (ce_i && accept) begin
          fsm_d    = LS_RUN;
          tgt_d    = req_tgt;
          fin_d    = req_fin;
          idx_d    = '0;
          cnt_d    = '0;
          load     = 1'b1;
          new_to   = req_tgt;
          new_idx  = '0;
        end
        LS_RUN: if (ce_i) begin
          if (cnt_q == dwell_q - TW'(1)) begin
            cnt_d = '0;
            if (!last_step) begin
              idx_d   = idx_q + 2'd1;
              load    = 1'b1;
              new_idx = idx_q + 2'd1;
            end else if (tgt_q != fin_q) begin
              // P<->N: the zero stop is reached, chain straight into zero->final.
              cur_d    = tgt_q;
              tgt_d    = fin_q;
              idx_d    = '0;
              load     = 1'b1;
              new_from = tgt_q;
              new_to   = fin_q;
              new_idx  = '0;
            end else begin
              cur_d = tgt_q;
              fsm_d = LS_IDLE;
            end
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
        default: fsm_d = LS_IDLE;
      endcase
    end
  end

  always_comb begin
    s_d       = s_q;
    dwell_d   = dwell_q;
    raw_dwell = t_short_i;
    unique case (step_new.dsel)
      DW_S: raw_dwell = t_short_i;
      DW_O: raw_dwell = t_off_on_i;
      DW_V: raw_dwell = t_on_offv0_i;
      DW_I: raw_dwell = t_off_oni0_i;
    endcase
    if (kill_i) begin
      s_d = '0;
    end else if (fsm_q == LS_FAULT) begin
      s_d = PAT_ZU2;
    end else if (load) begin
      s_d     = step_new.pat;
      dwell_d = (raw_dwell == '0) ? TW'(1) : raw_dwell;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q   <= LS_IDLE;
      cur_q   <= ST_ZU2;
      tgt_q   <= ST_ZU2;
      fin_q   <= ST_ZU2;
      idx_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      s_q     <= PAT_ZU2;
    end else begin
      fsm_q   <= fsm_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      fin_q   <= fin_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      s_q     <= s_d;
    end
  end

  assign s_o    = s_q;
  assign busy_o = (fsm_q == LS_RUN);

endmodule

// File: rtl/anpc3_leg_seq.sv
// Multi-leg ANPC commutation sequencer: fault latch and per-leg slicing.
// Define ANPC3_FAULT_EN to enable the latched fault shutdown.
module anpc3_leg_seq
  import anpc3_pkg::*;
#(
  parameter int unsigned LEGS = 3,
  parameter int unsigned TW   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic [TW-1:0]      t_short,
  input  logic [TW-1:0]      t_off_on,
  input  logic [TW-1:0]      t_on_offv0,
  input  logic [TW-1:0]      t_off_oni0,
  input  logic [2*LEGS-1:0]  v_lev,
  input  logic [1:0]         comm_type,
  input  logic               fault,
  input  logic               fault_clr,
  output logic [6*LEGS-1:0]  s_out,
  output logic [LEGS-1:0]    busy,
  output logic               fault_st
);

  logic kill;

`ifdef ANPC3_FAULT_EN
  logic fault_st_q, fault_st_d;

  always_comb begin
    fault_st_d = fault_st_q;
    if (fault)          fault_st_d = 1'b1;
    else if (fault_clr) fault_st_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_st_q <= 1'b0;
    else     fault_st_q <= fault_st_d;
  end

  // Live fault blanks gates on the same edge it is latched.
  assign kill     = fault | fault_st_q;
  assign fault_st = fault_st_q;
`else
  logic unused_fault_in;
  assign unused_fault_in = fault ^ fault_clr;
  assign kill            = 1'b0;
  assign fault_st        = 1'b0;
`endif

  for (genvar g = 0; g < LEGS; g++) begin : g_leg
    anpc3_leg #(.TW(TW)) u_leg (
      .clk_i        (clk),
      .rst_i        (rst),
      .ce_i         (ce),
      .t_short_i    (t_short),
      .t_off_on_i   (t_off_on),
      .t_on_offv0_i (t_on_offv0),
      .t_off_oni0_i (t_off_oni0),
      .req_i        (v_lev[2*g +: 2]),
      .comm_type_i  (comm_type),
      .kill_i       (kill),
      .s_o          (s_out[6*g +: 6]),
      .busy_o       (busy[g])
    );
  end

endmodule

// File: tb/tb_anpc3_leg_seq.sv
// Scoreboard bench for anpc3_leg_seq (3 legs); honours ANPC3_FAULT_EN.
module tb_anpc3_leg_seq;

  logic        clk, rst, ce;
  logic [9:0]  t_short, t_off_on, t_on_offv0, t_off_oni0;
  logic [5:0]  v_lev;
  logic [1:0]  comm_type;
  logic        fault, fault_clr;
  logic [17:0] s_out;
  logic [2:0]  busy;
  logic        fault_st;

  anpc3_leg_seq #(.LEGS(3), .TW(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .t_short    (t_short),
    .t_off_on   (t_off_on),
    .t_on_offv0 (t_on_offv0),
    .t_off_oni0 (t_off_oni0),
    .v_lev      (v_lev),
    .comm_type  (comm_type),
    .fault      (fault),
    .fault_clr  (fault_clr),
    .s_out      (s_out),
    .busy       (busy),
    .fault_st   (fault_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] s;
    logic [2:0]  b;
    logic        f;
  } snap_t;

  snap_t       sb_q[$];
  logic [17:0] m_s;
  logic [2:0]  m_b;
  logic        m_f;
  int          n_checks = 0;
  int          n_err    = 0;
  string       tname;

  localparam logic [5:0] ZU2 = 6'b010_010;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic exp_hold(input int n);
    snap_t e;
    e.s = m_s;
    e.b = m_b;
    e.f = m_f;
    repeat (n) sb_q.push_back(e);
  endtask

  task automatic exp_step(input int leg, input logic [5:0] pat, input logic b, input int n);
    m_s[leg*6 +: 6] = pat;
    m_b[leg]        = b;
    exp_hold(n);
  endtask

  task automatic set_lev(input int leg, input logic [1:0] v);
    v_lev[leg*2 +: 2] = v;
  endtask

  task automatic tick();
    snap_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk({tname, ":sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tname, ":s_out"}, 32'(s_out), 32'(e.s));
      chk({tname, ":busy"}, 32'(busy), 32'(e.b));
      chk({tname, ":fault_st"}, 32'(fault_st), 32'(e.f));
    end
  endtask

  task automatic drain();
    while (sb_q.size() != 0) tick();
  endtask

  initial begin
    rst        = 1'b1;
    ce         = 1'b1;
    v_lev      = '1;
    comm_type  = 2'd0;
    t_short    = 10'd2;
    t_off_on   = 10'd4;
    t_on_offv0 = 10'd3;
    t_off_oni0 = 10'd5;
    fault      = 1'b0;
    fault_clr  = 1'b0;
    m_s        = {3{ZU2}};
    m_b        = '0;
    m_f        = 1'b0;

    tname = "reset";
    repeat (3) @(negedge clk);
    chk("reset:s_out", 32'(s_out), 32'(m_s));
    chk("reset:busy", 32'(busy), 32'd0);
    chk("reset:fault_st", 32'(fault_st), 32'd0);
    rst = 1'b0;
    exp_hold(20);
    drain();

    tname = "leg0_zu2_to_p";
    set_lev(0, 2'd1);
    exp_step(0, 6'b010_000, 1'b1, 4);
    exp_step(0, 6'b110_000, 1'b1, 2);
    exp_step(0, 6'b110_001, 1'b1, 2);
    exp_step(0, 6'b110_001, 1'b0, 2);
    drain();

    tname = "leg1_zu2_to_p";
    set_lev(1, 2'd1);
    exp_step(1, 6'b010_000, 1'b1, 4);
    exp_step(1, 6'b110_000, 1'b1, 2);
    exp_step(1, 6'b110_001, 1'b1, 2);
    exp_step(1, 6'b110_001, 1'b0, 1);
    drain();

    tname = "leg1_p_zl1_n";
    comm_type = 2'd3;
    set_lev(1, 2'd2);
    exp_step(1, 6'b100_001, 1'b1, 4);
    exp_step(1, 6'b101_001, 1'b1, 2);
    exp_step(1, 6'b001_001, 1'b1, 5);
    exp_step(1, 6'b001_011, 1'b1, 2);
    exp_step(1, 6'b001_010, 1'b1, 4);
    exp_step(1, 6'b001_110, 1'b1, 2);
    exp_step(1, 6'b001_110, 1'b0, 2);
    drain();

    tname = "leg2_ce_stretch";
    t_short = 10'd3;
    set_lev(2, 2'd2);
    exp_step(2, 6'b011_010, 1'b1, 5);
    exp_step(2, 6'b001_010, 1'b1, 4);
    exp_step(2, 6'b001_110, 1'b1, 3);
    exp_step(2, 6'b001_110, 1'b0, 1);
    tick();
    ce = 1'b0;
    tick();
    tick();
    ce = 1'b1;
    drain();

    tname = "leg2_zero_dwell";
    comm_type  = 2'd2;
    t_on_offv0 = 10'd0;
    set_lev(2, 2'd0);
    exp_step(2, 6'b001_010, 1'b1, 4);
    exp_step(2, 6'b011_010, 1'b1, 1);
    exp_step(2, 6'b010_010, 1'b1, 3);
    exp_step(2, 6'b010_010, 1'b0, 2);
    drain();

    tname = "leg0_req_change";
    t_short   = 10'd2;
    comm_type = 2'd0;
    set_lev(0, 2'd0);
    exp_step(0, 6'b110_000, 1'b1, 2);
    exp_step(0, 6'b010_000, 1'b1, 4);
    exp_step(0, 6'b010_010, 1'b1, 2);
    exp_step(0, 6'b010_010, 1'b0, 1);
    exp_step(0, 6'b011_010, 1'b1, 2);
    exp_step(0, 6'b001_010, 1'b1, 4);
    exp_step(0, 6'b001_110, 1'b1, 2);
    exp_step(0, 6'b001_110, 1'b0, 1);
    tick();
    set_lev(0, 2'd2);
    drain();

    tname = "fault";
    comm_type = 2'd1;
    set_lev(1, 2'd1);
    exp_step(1, 6'b001_100, 1'b1, 1);
    tick();
    fault = 1'b1;
`ifdef ANPC3_FAULT_EN
    m_s = '0;
    m_b = '0;
    m_f = 1'b1;
    exp_hold(2);
    tick();
    tick();
    fault     = 1'b0;
    fault_clr = 1'b1;
    v_lev     = '1;
    m_f       = 1'b0;
    exp_hold(1);
    tick();
    fault_clr = 1'b0;
    m_s       = {3{ZU2}};
    exp_hold(3);
    drain();
`else
    exp_step(1, 6'b001_100, 1'b1, 1);
    exp_step(1, 6'b001_000, 1'b1, 4);
    exp_step(1, 6'b001_001, 1'b1, 2);
    exp_step(1, 6'b011_001, 1'b1, 2);
    exp_step(1, 6'b010_001, 1'b1, 4);
    exp_step(1, 6'b110_001, 1'b1, 2);
    exp_step(1, 6'b110_001, 1'b0, 1);
    tick();
    tick();
    fault     = 1'b0;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    v_lev     = '1;
    drain();
`endif

    tname = "async_reset";
    set_lev(2, 2'd1);
    exp_step(2, 6'b010_000, 1'b1, 1);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("async_reset:s_out", 32'(s_out), 32'({3{ZU2}}));
    chk("async_reset:busy", 32'(busy), 32'd0);
    chk("async_reset:fault_st", 32'(fault_st), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    v_lev = '1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/anpc3_leg_seq.md
# anpc3_leg_seq

Multi-leg commutation sequencer for 3-level ANPC converter legs. Each leg takes a requested output level and a commutation type, then steps its six gate signals through a fixed dead-time-safe sequence with programmable dwell times. It sits between the modulator (level requests) and the gate-driver outputs, and replicates one leg sequencer per phase. Over the single-leg version it adds:
- a `LEGS` parameter,
- a parametric timer width,
- clock-enable gating,
- direct P↔N requests routed through a zero state,
- a per-leg busy flag,
- an optional latched fault shutdown.

## Interface
Parameters:
- `LEGS`, 3, number of converter legs.
- `TW`, 10, width of dwell-time inputs and step counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `ce`  in  1  clock enable; when low, every leg freezes.
- `t_short`, `t_off_on`, `t_on_offv0`, `t_off_oni0`  in  TW each  dwell times in ce-cycles, shared by all legs.
- `v_lev`  in  2*LEGS  per-leg request, leg i at [2i+1:2i]: 0 = zero, 1 = P, 2 = N, 3 = hold.
- `comm_type`  in  2  0 = TYPE_I, 1 = TYPE_IU, 2 = TYPE_II, 3 = TYPE_III.
- `fault`  in  1  synchronous fault request, level-sensitive.
- `fault_clr`  in  1  one-cycle clear of a latched fault.
- `s_out`  out  6*LEGS  gate signals, leg i at [6i+5:6i], registered.
- `busy`  out  LEGS  leg is mid-sequence.
- `fault_st`  out  1  fault latched.

## Operation
Stable states and their patterns:
- P = 110_001
- ZU2 = 010_010
- ZU1 = 010_110
- ZL1 = 101_001
- ZL2 = 001_001
- N = 001_110

Zero target selected by `comm_type`:
- From P: TYPE_I → ZU2, TYPE_II → ZL2, TYPE_III → ZL1, TYPE_IU → ZU2.
- From N: TYPE_I → ZL2, TYPE_II → ZU2, TYPE_III → ZU1, TYPE_IU → ZL2.

Request handling:
- A request is accepted only when the leg is idle (busy=0) and ce=1.
- Ignored requests: zero while in a zero state, P while in P, N while in N, and value 3.
- Direct P↔N request: the leg runs P→zero(comm_type)→N (or the mirror) as two back-to-back sequences, with busy held high throughout.
- A request at a zero state goes directly to P or N.

Step lists, written as pattern/dwell, with s = t_short, o = t_off_on, v = t_on_offv0, i = t_off_oni0:
- ZU2→P: 010_000/o, 110_000/s, 110_001/s
- ZU2→N: 011_010/s, 001_010/o, 001_110/s
- ZU1→P: 010_010/i, 010_011/s, 010_001/o, 110_001/s
- ZU1→N: 000_110/o, 001_110/s
- ZL1→P: 100_001/o, 110_001/s
- ZL1→N: 001_001/i, 001_011/s, 001_010/o, 001_110/s
- ZL2→P: 011_001/s, 010_001/o, 110_001/s
- ZL2→N: 001_000/o, 001_100/s, 001_110/s
- P→ZU2: 110_000/s, 010_000/o, 010_010/s
- P→ZL1: 100_001/o, 101_001/s
- P→ZL2: 010_001/o, 011_001/s, 001_001/s
- N→ZU2: 001_010/o, 011_010/v, 010_010/s
- N→ZU1: 000_110/o, 010_110/s
- N→ZL2: 001_100/s, 001_000/o, 001_001/s

## Timing
- Reset values, per leg: state ZU2, s_out = 010_010, busy = 0, counters = 0; fault_st = 0.
- Acceptance: a request is accepted at clock edge k. The edge k then sets s_out to step0 and busy to 1.
- Step dwell: each step holds for exactly D ce-qualified cycles. A dwell value of D = 0 is treated as 1.
- Completion: the edge that ends the last step clears busy. s_out keeps the last-step pattern, which equals the target pattern. The next request can be accepted at that same edge+1.
- Request changes while busy are ignored. The request level is re-sampled only once the leg is idle.
- Dwell inputs are sampled at the start of each step. Later changes do not affect the current step.
- ce = 0: counters, states and s_out all hold; no request is accepted.
- Reset mid-sequence: the leg returns to the ZU2 pattern immediately (asynchronous).
- Counter arithmetic: TW-bit; the counter is cleared at every step boundary and never wraps.

## Configuration
`ANPC3_FAULT_EN`:
- Defined:
  - `fault` = 1 at an edge sets fault_st. All legs get s_out = 000_000 and busy = 0, overriding ce.
  - Requests are ignored while fault_st = 1.
  - `fault_clr` with fault = 0 clears fault_st. All legs then go to ZU2 (010_010) on the next edge.
- Undefined: the `fault` and `fault_clr` ports remain present but are ignored, and fault_st is tied to 0.

## Structure
- Package `anpc3_pkg`: state encoding, comm_type constants, stable-state patterns, the dwell-select enum (s/o/v/i), and the step-list lookup function.
- Sub-module `anpc3_leg`: one leg FSM with its step counter, instantiated LEGS times by generate.
- Top level: fault latch and bus slicing.

## Test plan
- Reset, then idle for 20 cycles → every leg shows s_out = 010_010, busy = 0.
- t_off_on = 4, t_short = 2, leg0 requests P from ZU2 → 010_000 for 4 cycles, 110_000 for 2, then 110_001; busy high for 8 cycles.
- TYPE_III, leg1 in P, v_lev = 2 → P→ZL1→N sequence, ending at 001_110 with no busy gap.
- ce toggled 1-0-1 during a dwell of 3 → step lengthened by exactly the number of ce-low cycles.
- v_lev changed mid-sequence → ignored; the new level is accepted at the first idle cycle.
- `ANPC3_FAULT_EN`: fault mid-sequence → all outputs 000_000 next edge; fault_clr → 010_010; with the macro undefined, fault has no effect.
